// File: rtl/incubator_pkg.sv
// Shared types and default limits for the incubator temperature path.
// Used by temp_sensor_conditioner (optional TEMP_SPIKE_REJECT_EN) and the incubator controller.
package incubator_pkg;

  typedef logic signed [7:0] temp_t;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    RUN  = 1'b1
  } cond_state_t;

  localparam temp_t DEFAULT_MIN_TEMP = -8'sd40;
  localparam temp_t DEFAULT_MAX_TEMP = 8'sd100;

  // Magnitude of a - b; 9 bits hold the full -255..255 difference range.
  function automatic logic [8:0] abs_diff(input temp_t a, input temp_t b);
    logic signed [8:0] d;
    d = {a[7], a} - {b[7], b};
    return d[8] ? 9'(-d) : 9'(d);
  endfunction

endpackage

// File: rtl/temp_sensor_conditioner_if.sv
// Sample/temperature bus between the sensor front-end and its consumer.
// Signal set is identical with or without TEMP_SPIKE_REJECT_EN.
interface temp_sensor_conditioner_if;
  import incubator_pkg::*;

  temp_t sample_in;
  logic  sample_valid;
  temp_t temperature;
  logic  temp_valid;
  logic  sensor_fault;

  modport master (
    output sample_in,
    output sample_valid,
    input  temperature,
    input  temp_valid,
    input  sensor_fault
  );

  modport slave (
    input  sample_in,
    input  sample_valid,
    output temperature,
    output temp_valid,
    output sensor_fault
  );

endinterface

// File: rtl/temp_window_buffer.sv
// Circular sample buffer with running sum and fill count for the moving average.
// Independent of TEMP_SPIKE_REJECT_EN.
module temp_window_buffer
  import incubator_pkg::*;
#(
  parameter int LOG2_WINDOW = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear,
  input  logic                          push,
  input  temp_t                         din,
  output logic signed [7+LOG2_WINDOW:0] sum,
  output logic                          full
);
  localparam int WINDOW = 1 << LOG2_WINDOW;
  localparam int SUM_W  = 8 + LOG2_WINDOW;
  localparam int CNT_W  = LOG2_WINDOW + 1;

  temp_t                   mem_q [WINDOW];
  logic [LOG2_WINDOW-1:0]  idx_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [SUM_W-1:0] sum_q;
  logic signed [SUM_W-1:0] sum_d;
  temp_t                   oldest_s;

  // Entry at the write index is the oldest one once the window has wrapped.
  always_comb begin
    oldest_s = mem_q[idx_q];
    sum_d    = sum_q + {{LOG2_WINDOW{din[7]}}, din} - {{LOG2_WINDOW{oldest_s[7]}}, oldest_s};
  end

  // Buffer, index, fill count and sum storage.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      for (int i = 0; i < WINDOW; i++) begin
        mem_q[i] <= 8'sd0;
      end
      idx_q <= {LOG2_WINDOW{1'b0}};
      cnt_q <= {CNT_W{1'b0}};
      sum_q <= {SUM_W{1'b0}};
    end else if (push) begin
      mem_q[idx_q] <= din;
      idx_q        <= idx_q + LOG2_WINDOW'(1);
      sum_q        <= sum_d;
      if (!full) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign sum  = sum_q;
  assign full = (cnt_q == CNT_W'(WINDOW));

endmodule

// File: rtl/temp_sensor_conditioner.sv
// Sensor front-end: range check, moving average, stale-data timeout and fault flag.
// Define TEMP_SPIKE_REJECT_EN to build the RUN-state spike filter.
module temp_sensor_conditioner
  import incubator_pkg::*;
#(
  parameter int    LOG2_WINDOW    = 2,
  parameter temp_t MIN_TEMP       = DEFAULT_MIN_TEMP,
  parameter temp_t MAX_TEMP       = DEFAULT_MAX_TEMP,
  parameter int    FAULT_LIMIT    = 3,
  parameter int    TIMEOUT_CYCLES = 1000
`ifdef TEMP_SPIKE_REJECT_EN
  ,
  parameter int    SPIKE_LIMIT    = 15
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  temp_sensor_conditioner_if.slave bus
);
  localparam int IDLE_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FAULT_W = $clog2(FAULT_LIMIT + 1);
  localparam int SUM_W   = 8 + LOG2_WINDOW;

  logic                    in_range_s;
  logic                    cand_s;
  logic                    accept_s;
  logic                    timeout_s;
  logic                    full_s;
  logic signed [SUM_W-1:0] sum_s;
  temp_t                   avg_s;
  logic [IDLE_W-1:0]       idle_q;
  logic [IDLE_W-1:0]       idle_d;
  logic [FAULT_W-1:0]      fault_cnt_q;
  logic [FAULT_W-1:0]      fault_cnt_d;
  logic                    sensor_fault_q;
  logic                    sensor_fault_d;
  cond_state_t             state_q;
  logic                    upd_q;
  temp_t                   temperature_q;
  logic                    temp_valid_q;

  // Inclusive signed range check qualifies a sample as a candidate.
  always_comb begin
    in_range_s = (bus.sample_in >= MIN_TEMP) && (bus.sample_in <= MAX_TEMP);
    cand_s     = bus.sample_valid && in_range_s;
  end

`ifdef TEMP_SPIKE_REJECT_EN
  logic [1:0] spike_cnt_q;
  logic       spike_s;

  // A third consecutive spike is taken as a genuine step in temperature.
  always_comb begin
    spike_s  = (state_q == RUN) && (abs_diff(bus.sample_in, temperature_q) > 9'(SPIKE_LIMIT));
    accept_s = cand_s && (!spike_s || (spike_cnt_q == 2'd2));
  end

  // Consecutive spike discard counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      spike_cnt_q <= 2'd0;
    end else if (accept_s) begin
      spike_cnt_q <= 2'd0;
    end else if (cand_s && spike_s) begin
      spike_cnt_q <= spike_cnt_q + 2'd1;
    end
  end
`else
  // Every in-range sample is accepted.
  always_comb begin
    accept_s = cand_s;
  end
`endif

  // Idle timeout and saturating out-of-range counter; an accept wins over a timeout.
  always_comb begin
    timeout_s = !accept_s && (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1));
    if (accept_s || timeout_s) begin
      idle_d = {IDLE_W{1'b0}};
    end else begin
      idle_d = idle_q + IDLE_W'(1);
    end
    if (accept_s) begin
      fault_cnt_d = {FAULT_W{1'b0}};
    end else if (bus.sample_valid && !in_range_s && (fault_cnt_q != FAULT_W'(FAULT_LIMIT))) begin
      fault_cnt_d = fault_cnt_q + FAULT_W'(1);
    end else begin
      fault_cnt_d = fault_cnt_q;
    end
    sensor_fault_d = (fault_cnt_d == FAULT_W'(FAULT_LIMIT));
    avg_s          = temp_t'(sum_s >>> LOG2_WINDOW);
  end

  // Idle and fault supervision registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_q         <= {IDLE_W{1'b0}};
      fault_cnt_q    <= {FAULT_W{1'b0}};
      sensor_fault_q <= 1'b0;
    end else begin
      idle_q         <= idle_d;
      fault_cnt_q    <= fault_cnt_d;
      sensor_fault_q <= sensor_fault_d;
    end
  end

  // FILL/RUN state machine; the average is published one edge after the sum moves.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FILL;
      upd_q         <= 1'b0;
      temperature_q <= 8'sd0;
      temp_valid_q  <= 1'b0;
    end else begin
      upd_q <= accept_s;
      if (timeout_s) begin
        state_q      <= FILL;
        temp_valid_q <= 1'b0;
      end else begin
        case (state_q)
          FILL: begin
            if (upd_q && full_s) begin
              state_q       <= RUN;
              temp_valid_q  <= 1'b1;
              temperature_q <= avg_s;
            end
          end
          RUN: begin
            if (upd_q) begin
              temperature_q <= avg_s;
            end
          end
          default: begin
            state_q      <= FILL;
            temp_valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  temp_window_buffer #(
    .LOG2_WINDOW(LOG2_WINDOW)
  ) u_window (
    .clk   (clk),
    .reset (reset),
    .clear (timeout_s),
    .push  (accept_s),
    .din   (bus.sample_in),
    .sum   (sum_s),
    .full  (full_s)
  );

  assign bus.temperature  = temperature_q;
  assign bus.temp_valid   = temp_valid_q;
  assign bus.sensor_fault = sensor_fault_q;

endmodule

// File: tb/tb_temp_sensor_conditioner.sv
// Self-checking bench for temp_sensor_conditioner against a queue-based reference model.
// Spike scenarios are included when TEMP_SPIKE_REJECT_EN is defined.
module tb_temp_sensor_conditioner;
  import incubator_pkg::*;

  localparam int W       = 4;
  localparam int TIMEOUT = 1000;
  localparam int FLIMIT  = 3;
  localparam int MINT    = -40;
  localparam int MAXT    = 100;
  localparam int SPIKE   = 15;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  temp_sensor_conditioner_if bus();

  temp_sensor_conditioner dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: accepted samples since the last clear, newest last.
  int win[$];
  bit pend;
  int m_temp;
  bit m_valid;
  bit m_fault;
  int fcnt;
  int idle;
  int spikes;

  function automatic int floor_div(input int a);
    return (a >= 0) ? a / W : -((-a + W - 1) / W);
  endfunction

  task automatic model_edge(input bit v, input int s);
    bit acc;
    bit oor;
    int sum;
    if (reset) begin
      win.delete();
      pend = 0; m_temp = 0; m_valid = 0; m_fault = 0; fcnt = 0; idle = 0; spikes = 0;
      return;
    end
    acc = v && (s >= MINT) && (s <= MAXT);
    oor = v && !acc;
`ifdef TEMP_SPIKE_REJECT_EN
    if (acc && m_valid && ((s - m_temp > SPIKE) || (m_temp - s > SPIKE)) && (spikes < 2)) begin
      acc = 0;
      spikes++;
    end
    if (acc) spikes = 0;
`endif
    if (pend && win.size() == W) begin
      sum = 0;
      foreach (win[i]) sum += win[i];
      m_temp  = floor_div(sum);
      m_valid = 1;
    end
    if (acc) begin
      win.push_back(s);
      if (win.size() > W) void'(win.pop_front());
      idle = 0;
      fcnt = 0;
    end else begin
      idle++;
      if (idle == TIMEOUT) begin
        win.delete();
        m_valid = 0;
        idle    = 0;
      end
      if (oor && fcnt < FLIMIT) fcnt++;
    end
    m_fault = (fcnt == FLIMIT);
    pend    = acc;
  endtask

  task automatic step(input bit v, input int s);
    bus.sample_valid = v;
    bus.sample_in    = temp_t'(s);
    @(posedge clk);
    model_edge(v, s);
    #1;
    bus.sample_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(1, 50);
    step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd0) begin n_fail++; $display("FAIL reset_temp: got %0d expected 0", bus.temperature); end
    n_tests++; if (bus.temp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", bus.temp_valid); end
    n_tests++; if (bus.sensor_fault !== 1'b0) begin n_fail++; $display("FAIL reset_fault: got %0b expected 0", bus.sensor_fault); end
    reset = 1'b0;
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) step(1, 20);
    n_tests++; if (bus.temp_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid_early: got %0b expected 0", bus.temp_valid); end
    step(0, 0);
    n_tests++; if (bus.temp_valid !== 1'b1) begin n_fail++; $display("FAIL fill_valid: got %0b expected 1", bus.temp_valid); end
    n_tests++; if (bus.temperature !== 8'sd20) begin n_fail++; $display("FAIL fill_temp: got %0d expected 20", bus.temperature); end
  endtask

  task automatic test_average();
    step(1, 24);
    step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd21) begin n_fail++; $display("FAIL avg_24: got %0d expected 21", bus.temperature); end
    for (int i = 0; i < 4; i++) step(1, -5);
    step(0, 0);
    n_tests++; if (bus.temperature !== temp_t'(m_temp)) begin n_fail++; $display("FAIL avg_neg_model: got %0d expected %0d", bus.temperature, m_temp); end
`ifndef TEMP_SPIKE_REJECT_EN
    n_tests++; if (bus.temperature !== -8'sd5) begin n_fail++; $display("FAIL avg_neg: got %0d expected -5", bus.temperature); end
`endif
  endtask

  task automatic test_floor();
    for (int i = 0; i < 4; i++) step(1, -3);
    step(0, 0);
    n_tests++; if (bus.temperature !== temp_t'(m_temp)) begin n_fail++; $display("FAIL floor_m3_model: got %0d expected %0d", bus.temperature, m_temp); end
    step(1, -4);
    step(0, 0);
    n_tests++; if (bus.temperature !== temp_t'(m_temp)) begin n_fail++; $display("FAIL floor_m4_model: got %0d expected %0d", bus.temperature, m_temp); end
`ifndef TEMP_SPIKE_REJECT_EN
    n_tests++; if (bus.temperature !== -8'sd4) begin n_fail++; $display("FAIL floor_m4: got %0d expected -4", bus.temperature); end
`endif
  endtask

  task automatic test_fault();
    step(1, 120);
    step(1, 120);
    n_tests++; if (bus.sensor_fault !== 1'b0) begin n_fail++; $display("FAIL fault_early: got %0b expected 0", bus.sensor_fault); end
    step(1, 120);
    n_tests++; if (bus.sensor_fault !== 1'b1) begin n_fail++; $display("FAIL fault_set: got %0b expected 1", bus.sensor_fault); end
    n_tests++; if (bus.temperature !== temp_t'(m_temp)) begin n_fail++; $display("FAIL fault_temp_hold: got %0d expected %0d", bus.temperature, m_temp); end
    step(1, 25);
    n_tests++; if (bus.sensor_fault !== m_fault) begin n_fail++; $display("FAIL fault_clear_model: got %0b expected %0b", bus.sensor_fault, m_fault); end
`ifndef TEMP_SPIKE_REJECT_EN
    n_tests++; if (bus.sensor_fault !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got %0b expected 0", bus.sensor_fault); end
`endif
  endtask

  task automatic test_timeout();
    int held;
    held = 0;
    step(1, m_temp);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      step(0, 0);
      if (i == 0) held = m_temp;
    end
    n_tests++; if (bus.temp_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_early: got %0b expected 1", bus.temp_valid); end
    step(0, 0);
    n_tests++; if (bus.temp_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_valid: got %0b expected 0", bus.temp_valid); end
    n_tests++; if (bus.temperature !== temp_t'(held)) begin n_fail++; $display("FAIL timeout_temp_hold: got %0d expected %0d", bus.temperature, held); end
    for (int i = 0; i < 4; i++) step(1, 30);
    n_tests++; if (bus.temp_valid !== 1'b0) begin n_fail++; $display("FAIL refill_early: got %0b expected 0", bus.temp_valid); end
    step(0, 0);
    n_tests++; if (bus.temp_valid !== 1'b1) begin n_fail++; $display("FAIL refill_valid: got %0b expected 1", bus.temp_valid); end
    n_tests++; if (bus.temperature !== 8'sd30) begin n_fail++; $display("FAIL refill_temp: got %0d expected 30", bus.temperature); end
  endtask

  task automatic test_reset_mid_fill();
    pulse_reset();
    step(1, 40);
    step(1, 40);
    for (int i = 0; i < 3; i++) step(1, 120);
    n_tests++; if (bus.sensor_fault !== 1'b1) begin n_fail++; $display("FAIL midfill_fault_pre: got %0b expected 1", bus.sensor_fault); end
    reset = 1'b1;
    step(1, 40);
    reset = 1'b0;
    n_tests++; if (bus.sensor_fault !== 1'b0) begin n_fail++; $display("FAIL midfill_fault: got %0b expected 0", bus.sensor_fault); end
    n_tests++; if (bus.temp_valid !== 1'b0) begin n_fail++; $display("FAIL midfill_valid: got %0b expected 0", bus.temp_valid); end
    n_tests++; if (bus.temperature !== 8'sd0) begin n_fail++; $display("FAIL midfill_temp: got %0d expected 0", bus.temperature); end
    for (int i = 0; i < 3; i++) step(1, 40);
    step(0, 0);
    n_tests++; if (bus.temp_valid !== 1'b0) begin n_fail++; $display("FAIL midfill_three: got %0b expected 0", bus.temp_valid); end
    step(1, 40);
    step(0, 0);
    n_tests++; if (bus.temp_valid !== 1'b1) begin n_fail++; $display("FAIL midfill_four: got %0b expected 1", bus.temp_valid); end
    n_tests++; if (bus.temperature !== 8'sd40) begin n_fail++; $display("FAIL midfill_temp4: got %0d expected 40", bus.temperature); end
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    step(1, 10); step(1, 12); step(1, 14); step(1, 16);
    step(1, 18);
    n_tests++; if (bus.temp_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %0b expected 1", bus.temp_valid); end
    n_tests++; if (bus.temperature !== 8'sd13) begin n_fail++; $display("FAIL b2b_first: got %0d expected 13", bus.temperature); end
    step(1, 20);
    n_tests++; if (bus.temperature !== 8'sd15) begin n_fail++; $display("FAIL b2b_second: got %0d expected 15", bus.temperature); end
    step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd17) begin n_fail++; $display("FAIL b2b_third: got %0d expected 17", bus.temperature); end
  endtask

  task automatic test_range_edges();
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 100);
    step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd100) begin n_fail++; $display("FAIL all_max: got %0d expected 100", bus.temperature); end
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, -40);
    step(0, 0);
    n_tests++; if (bus.temperature !== -8'sd40) begin n_fail++; $display("FAIL all_min: got %0d expected -40", bus.temperature); end
    pulse_reset();
    step(1, -40); step(1, -40); step(1, 100); step(1, 100);
    step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd30) begin n_fail++; $display("FAIL mixed_edges: got %0d expected 30", bus.temperature); end
    step(1, -41);
    step(1, 101);
    n_tests++; if (bus.sensor_fault !== 1'b0) begin n_fail++; $display("FAIL edge_fault_two: got %0b expected 0", bus.sensor_fault); end
    step(1, 101);
    n_tests++; if (bus.sensor_fault !== 1'b1) begin n_fail++; $display("FAIL edge_fault_three: got %0b expected 1", bus.sensor_fault); end
    n_tests++; if (bus.temperature !== 8'sd30) begin n_fail++; $display("FAIL edge_temp_hold: got %0d expected 30", bus.temperature); end
  endtask

`ifdef TEMP_SPIKE_REJECT_EN
  task automatic test_spike();
    pulse_reset();
    for (int i = 0; i < 4; i++) step(1, 20);
    step(0, 0);
    step(1, 50); step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd20) begin n_fail++; $display("FAIL spike_one: got %0d expected 20", bus.temperature); end
    step(1, 50); step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd20) begin n_fail++; $display("FAIL spike_two: got %0d expected 20", bus.temperature); end
    step(1, 50); step(0, 0);
    n_tests++; if (bus.temperature !== 8'sd27) begin n_fail++; $display("FAIL spike_three: got %0d expected 27", bus.temperature); end
  endtask
`endif

  task automatic test_random();
    bit v;
    int s;
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(3, 0) != 0);
      s = int'($urandom_range(180, 0)) - 60;
      step(v, s);
      n_tests++; if (bus.temperature !== temp_t'(m_temp)) begin n_fail++; $display("FAIL rand_temp[%0d]: got %0d expected %0d", i, bus.temperature, m_temp); end
      n_tests++; if (bus.temp_valid !== m_valid) begin n_fail++; $display("FAIL rand_valid[%0d]: got %0b expected %0b", i, bus.temp_valid, m_valid); end
      n_tests++; if (bus.sensor_fault !== m_fault) begin n_fail++; $display("FAIL rand_fault[%0d]: got %0b expected %0b", i, bus.sensor_fault, m_fault); end
    end
  endtask

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in    = 8'sd0;
    test_reset();
    test_fill();
    test_average();
    test_floor();
    test_fault();
    test_timeout();
    test_reset_mid_fill();
    test_back_to_back();
    test_range_edges();
`ifdef TEMP_SPIKE_REJECT_EN
    test_spike();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
